phase_sig_gen: RTL
==================

# phase_sig_gen

Programmable dual square-wave generator, the stimulus end of the phase-difference measurement path. It produces two same-frequency signals, `sig_out0` (reference) and `sig_out1` (lagging copy), with period, high time and phase lag set in `sys_clk` ticks. It drives the phase/frequency meter inputs for closed-loop self-test and calibration. Configuration takes effect only at period boundaries, so the output never carries a truncated or glitched cycle.

## Interface
- `CNT_W`, default 32: width of the period, high-time and phase fields and of the internal counters.
- `sys_clk  in  1`: system clock; all logic is on its rising edge.
- `rst  in  1`: asynchronous reset, active-high.
- `cfg_valid  in  1`: configuration offer.
- `cfg_ready  out  1`: the block can take a configuration.
- `cfg_period  in  CNT_W`: period in ticks.
- `cfg_high  in  CNT_W`: high time in ticks.
- `cfg_phase  in  CNT_W`: lag of `sig_out1` behind `sig_out0`, in ticks.
- `enable  in  1`: run request, level-sensitive.
- `sig_out0  out  1`: reference square wave, registered.
- `sig_out1  out  1`: lagged square wave, registered.
- `running  out  1`: high while in RUN.
- `cfg_err  out  1`: one-cycle pulse when an offered configuration is rejected.

## Operation
- **Handshake:** a transfer happens when `cfg_valid && cfg_ready` on an edge. Fields are sampled on that edge only.
- **Validity check:** a configuration is valid iff `period >= 2`, `1 <= high <= period-1` and `phase <= period-1`.
  - Invalid: the handshake still completes, `cfg_err` = 1 for the next cycle, and active and pending settings are unchanged.
- **Storage:** there is an active register set and a one-deep pending set.
  - In IDLE, a valid configuration loads directly into active and sets `loaded`.
  - In RUN, it loads into pending and `cfg_ready` drops to 0.
- **`cfg_ready`:** 1 except when pending is full. After reset, `cfg_ready` = 1.
- **States:** two states, IDLE and RUN.
  - IDLE -> RUN when `enable` = 1 and `loaded` = 1.
  - RUN -> IDLE on the wrap edge (`cnt0 == period-1`) if `enable` = 0 at that edge. A period in progress always completes.
- **Counter `cnt0`:** runs 0..period-1 and wraps to 0. Entering RUN sets `cnt0` = 0.
- **Phase counter:** `cnt1 = (cnt0 >= phase) ? cnt0 - phase : cnt0 + period - phase`. The compare is unsigned and the result is `CNT_W` bits with no overflow, since `phase < period`.
- **Output equations:**
  - `sig_out0 = RUN && (cnt0 < high)`.
  - `sig_out1 = RUN && armed1 && (cnt1 < high)`.
- **`armed1`:** cleared on entry to RUN, and set once `phase` ticks have elapsed since entry (immediately if phase = 0). This makes the first `sig_out1` rise exactly `phase` ticks after the first `sig_out0` rise, with no spurious initial high pulse.
- **Pending apply:** on a wrap edge with pending full, pending moves to active and `cfg_ready` returns to 1 on the same edge. The new period starts with the new values. `armed1` is not cleared, so the lag changes with no dead cycle.
- **Simultaneous events:**
  - Handshake on the same edge as a wrap that applies pending: the handshake cannot happen, because `cfg_ready` = 0.
  - Wrap edge with `enable` = 0 and pending full: pending is applied and the state goes to IDLE.

## Timing
- **Reset values:**
  - `sig_out0` = `sig_out1` = 0, `running` = 0, `cfg_err` = 0, `cfg_ready` = 1.
  - State IDLE, `loaded` = 0, counters 0, pending empty.
- **Reset mid-run:** reset asserted mid-run forces all of the above immediately, asynchronously.
- **Start latency:** on the edge that samples `enable` = 1 in IDLE (with `loaded`), `running`, `sig_out0` and `cnt0` = 0 all take effect. `sig_out0` is high from that edge.
- **Lag:** the first `sig_out1` rise is `phase` edges after the `sig_out0` rise. Thereafter each `sig_out1` edge trails the matching `sig_out0` edge by exactly `phase` edges.
- **Waveform:** `sig_out0` is high for `high` cycles and low for `period - high` cycles.
- **Stop:** after the last wrap, both outputs are 0 from the RUN->IDLE edge.
  - `sig_out1` may be truncated at stop when `phase > period - high`; this is accepted.
- **`cfg_err`:** pulses on the edge after the rejected handshake and lasts exactly 1 cycle.

## Test plan
- **Basic waveform:** `period`=10, `high`=5, `phase`=3, `enable`=1 -> `sig_out0` rises at edge E and `sig_out1` at E+3; both are high 5 and low 5, repeating every 10 edges.
- **Zero lag:** `phase`=0 -> `sig_out1` is identical to `sig_out0` cycle for cycle.
- **Wrapped lag:** `period`=8, `high`=6, `phase`=7 -> `sig_out1` is low for the first 7 edges, then is `sig_out0` delayed by 7; no high pulse appears before E+7.
- **Rejected configurations:** `period`=1, `high`=0, or `phase`=`period` -> `cfg_err` pulses 1 cycle and the running waveform is unchanged.
- **Reconfiguration while running:** mid-period, offer `period`=20, `high`=4, `phase`=2 -> `cfg_ready` goes to 0 and the current 10-tick period completes. The new waveform starts exactly at the wrap edge, and `cfg_ready` = 1 on that edge.
- **Stop, then reset:** drop `enable` at `cnt0`=2 -> the period completes and `running` = 0 at the wrap. Then assert `rst` mid-run -> all outputs are at reset values with no clock edge.

Source files
------------

// File: rtl/phase_sig_gen.sv
// rtl/phase_sig_gen.sv - programmable dual square-wave generator with phase-lagged copy
module phase_sig_gen #(
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             enable,
    output logic             sig_out0,
    output logic             sig_out1,
    output logic             running,
    output logic             cfg_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state, nxt_state;
    logic [CNT_W-1:0] act_period, act_high, act_phase;
    logic [CNT_W-1:0] nxt_period, nxt_high, nxt_phase;
    logic [CNT_W-1:0] pend_period, pend_high, pend_phase;
    logic [CNT_W-1:0] nxt_pend_period, nxt_pend_high, nxt_pend_phase;
    logic             pend_full, nxt_pend_full;
    logic             loaded, nxt_loaded;
    logic [CNT_W-1:0] cnt0, nxt_cnt0, nxt_cnt1;
    logic             armed1, nxt_armed1;
    logic             handshake, cfg_ok, wrap;

    assign cfg_ready = ~pend_full;
    assign handshake = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
                       (cfg_high < cfg_period) && (cfg_phase < cfg_period);
    assign wrap      = (state == ST_RUN) && (cnt0 == act_period - CNT_W'(1));

    // Outputs are registered from the next-state values so they line up with cnt0.
    always_comb begin
        nxt_state       = state;
        nxt_period      = act_period;
        nxt_high        = act_high;
        nxt_phase       = act_phase;
        nxt_pend_period = pend_period;
        nxt_pend_high   = pend_high;
        nxt_pend_phase  = pend_phase;
        nxt_pend_full   = pend_full;
        nxt_loaded      = loaded;
        nxt_cnt0        = cnt0;
        nxt_armed1      = 1'b0;
        if (state == ST_IDLE) begin
            if (handshake && cfg_ok) begin
                nxt_period = cfg_period;
                nxt_high   = cfg_high;
                nxt_phase  = cfg_phase;
                nxt_loaded = 1'b1;
            end
            if (enable && loaded) begin
                nxt_state  = ST_RUN;
                nxt_cnt0   = '0;
                nxt_armed1 = (nxt_phase == '0);
            end
        end else begin
            if (handshake && cfg_ok) begin
                nxt_pend_period = cfg_period;
                nxt_pend_high   = cfg_high;
                nxt_pend_phase  = cfg_phase;
                nxt_pend_full   = 1'b1;
            end
            if (wrap) begin
                nxt_cnt0 = '0;
                if (pend_full) begin
                    nxt_period    = pend_period;
                    nxt_high      = pend_high;
                    nxt_phase     = pend_phase;
                    nxt_pend_full = 1'b0;
                end
                if (!enable) begin
                    nxt_state = ST_IDLE;
                end
            end else begin
                nxt_cnt0 = cnt0 + CNT_W'(1);
            end
            // armed1 survives a pending apply so the lag change has no dead cycle
            nxt_armed1 = (nxt_state == ST_RUN) && (armed1 || (nxt_cnt0 == nxt_phase));
        end
        nxt_cnt1 = (nxt_cnt0 >= nxt_phase) ? (nxt_cnt0 - nxt_phase)
                                            : (nxt_cnt0 + nxt_period - nxt_phase);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            act_period  <= '0;
            act_high    <= '0;
            act_phase   <= '0;
            pend_period <= '0;
            pend_high   <= '0;
            pend_phase  <= '0;
            pend_full   <= 1'b0;
            loaded      <= 1'b0;
            cnt0        <= '0;
            armed1      <= 1'b0;
            sig_out0    <= 1'b0;
            sig_out1    <= 1'b0;
            running     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= nxt_state;
            act_period  <= nxt_period;
            act_high    <= nxt_high;
            act_phase   <= nxt_phase;
            pend_period <= nxt_pend_period;
            pend_high   <= nxt_pend_high;
            pend_phase  <= nxt_pend_phase;
            pend_full   <= nxt_pend_full;
            loaded      <= nxt_loaded;
            cnt0        <= nxt_cnt0;
            armed1      <= nxt_armed1;
            sig_out0    <= (nxt_state == ST_RUN) && (nxt_cnt0 < nxt_high);
            sig_out1    <= (nxt_state == ST_RUN) && nxt_armed1 && (nxt_cnt1 < nxt_high);
            running     <= (nxt_state == ST_RUN);
            cfg_err     <= handshake && !cfg_ok;
        end
    end

endmodule
